instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
Fetch stage sitting directly upstream of instruction_memory. Owns the program counter, drives the memory address, and captures the returned word into an IF/ID output register for the decoder. Uses a valid/ready handshake toward decode and accepts branch/jump redirects from execute. The memory is combinational: the instruction for addr is available in the same cycle.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  32  byte address to instruction_memory; always equal to pc
imem_instr  input  32  instruction word from instruction_memory for imem_addr
redirect_valid  input  1  taken branch/jump this cycle
redirect_pc  input  32  redirect target byte address
out_valid  output  1  IF/ID register holds a valid instruction
out_ready  input  1  decode accepts the IF/ID contents this cycle
out_instr  output  32  fetched instruction
out_pc  output  32  address of out_instr
out_pc_plus4  output  32  out_pc + 4, modulo 2^32
fault  output  1  sticky misaligned-redirect indicator

Behaviour:
- Reset (rst=1 at an edge), regardless of other inputs: pc<=RESET_PC, state<=FETCH, out_valid<=0, out_instr<=0, out_pc<=0, out_pc_plus4<=0, fault<=0. Reset mid-stream discards any held instruction.
- imem_addr = pc, combinationally, in every state.
- States: FETCH, FAULT.
- FETCH, per-edge priority: redirect > advance > hold.
  - redirect_valid=1 with redirect_pc[1:0]==0: pc<=redirect_pc and out_valid<=0 (flush of the wrong-path instruction), independent of out_ready. No capture occurs that cycle. The first instruction at the target appears with out_valid=1 one edge later.
  - redirect_valid=1 with redirect_pc[1:0]!=0: fault<=1, state<=FAULT, out_valid<=0, pc unchanged.
  - advance condition is (!out_valid || out_ready) with no redirect. Effects: out_instr<=imem_instr, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
  - hold (out_valid && !out_ready): pc and all out_* stay stable. Outputs must not change while valid and not ready.
- FAULT: pc frozen, out_valid=0, fault=1, and redirect is ignored. Only rst exits this state.
- Throughput: one instruction per cycle while out_ready=1. Latency from pc to out_valid is one edge.
- Arithmetic: pc+4 is a 32-bit wrap. pc=32'hFFFF_FFFC advances to 32'h0000_0000, and out_pc_plus4 is 0 for that word.
- Simultaneous redirect and out_ready=1: the redirect wins. The held instruction is consumed by decode that cycle and is not re-presented.
- pc[1:0] is always 0 and is never modified by advance.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - constants INSTR_BYTES=4 and NOP_INSTR=32'h0000_0013 (reserved for later flush injection);
  - a state enum with FETCH and FAULT;
  - an if_id_t struct with instr, pc, pc_plus4.
- One natural sub-module is pc_reg, which covers the PC register, next-PC mux and alignment check. The IF/ID register stays in the top.

Test Plan:
- Reset then out_ready=1 for 4 cycles, with the memory returning 0x11,0x22,0x33,0x44 at 0,4,8,12:
  - out_valid rises one edge after reset release;
  - out_pc runs 0,4,8,12 with the matching instr;
  - imem_addr runs 0,4,8,12,16.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4. Then out_instr=0x22, out_pc=4 and imem_addr=8 hold. After out_ready=1, the sequence resumes at pc 8 with no word dropped or duplicated.
- Redirect to 0x100 while out_valid=1 and out_ready=0. Next edge gives out_valid=0. The edge after gives out_pc=0x100 and out_pc_plus4=0x104.
- Misaligned redirect to 0x102. Then fault=1 and out_valid=0, and imem_addr stays frozen for 5 cycles despite further redirects to 0x200. Asserting rst gives fault=0 and imem_addr=RESET_PC.
- Wrap: redirect to 0xFFFF_FFFC. Then out_pc=0xFFFF_FFFC, out_pc_plus4=0, and the next out_pc is 0x0.
- rst asserted mid-stream at out_pc=8 with out_ready=0. Next edge gives out_valid=0, out_* all 0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/rv_fetch_pkg.sv
// Shared fetch-stage types and constants: state encoding and the IF/ID payload.
package rv_fetch_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ALIGN_BITS  = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection and redirect alignment check.
module pc_reg
    import rv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_inc_c,
    output logic            misaligned_c
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    assign pc_inc_c     = pc_q + XLEN'(INSTR_BYTES);
    assign misaligned_c = |redirect_pc_i[ALIGN_BITS-1:0];

    // Redirect is only asserted by the caller for aligned targets, so pc stays aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = redirect_pc_i;
        end else if (advance_i) begin
            pc_d = pc_inc_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives instruction memory from the PC and holds the IF/ID register toward decode.
module instruction_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault
);

    fetch_state_e    state_q, state_d;
    if_id_t          if_id_q, if_id_d;
    logic            out_valid_q, out_valid_d;
    logic            fault_q, fault_d;
    logic            advance_c;
    logic            load_redirect_c;
    logic            misaligned_c;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc_c;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .advance_i     (advance_c),
        .redirect_i    (load_redirect_c),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc),
        .pc_inc_c      (pc_inc_c),
        .misaligned_c  (misaligned_c)
    );

    // Priority in FETCH: redirect, then advance, otherwise hold everything.
    always_comb begin
        state_d         = state_q;
        if_id_d         = if_id_q;
        out_valid_d     = out_valid_q;
        fault_d         = fault_q;
        advance_c       = 1'b0;
        load_redirect_c = 1'b0;
        case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    if (misaligned_c) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        load_redirect_c = 1'b1;
                    end
                end else if (!out_valid_q || out_ready) begin
                    advance_c        = 1'b1;
                    out_valid_d      = 1'b1;
                    if_id_d.instr    = imem_instr;
                    if_id_d.pc       = pc;
                    if_id_d.pc_plus4 = pc_inc_c;
                end
            end
            FAULT: begin
                out_valid_d = 1'b0;
                fault_d     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            if_id_q     <= '0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            if_id_q     <= if_id_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
        end
    end

    assign imem_addr    = pc;
    assign out_valid    = out_valid_q;
    assign out_instr    = if_id_q.instr;
    assign out_pc       = if_id_q.pc;
    assign out_pc_plus4 = if_id_q.pc_plus4;
    assign fault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: stream model checked every cycle plus directed literal checks.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instruction_fetch #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .fault          (fault)
    );

    // Memory image: the first four words are 0x11..0x44, the rest derive from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd16) return ((a >> 2) + 32'd1) * 32'h11;
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: the word at fetch address goes out when the slot is free.
    logic [31:0] m_pc, m_instr, m_opc;
    logic        m_valid, m_fault;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_opc = 32'h0; m_fault = 1'b0;
            m_live = 1'b1;
        end else if (m_live && !m_fault) begin
            if (redirect_valid) begin
                m_valid = 1'b0;
                if (redirect_pc % 4 != 0) m_fault = 1'b1;
                else m_pc = redirect_pc;
            end else if (!m_valid || out_ready) begin
                m_instr = mem_word(m_pc);
                m_opc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    end

    // The IF/ID register only carries meaning while valid; after reset it must read as zero.
    always @(posedge clk) begin
        #1;
        if (m_live) begin
            check("m_imem_addr", imem_addr, m_pc);
            check("m_out_valid", 32'(out_valid), 32'(m_valid));
            check("m_fault", 32'(fault), 32'(m_fault));
            check("m_out_instr", out_instr, m_instr);
            check("m_out_pc", out_pc, m_opc);
            check("m_out_pc_plus4", out_pc_plus4, (m_opc == 32'h0 && m_instr == 32'h0 && !m_valid) ? 32'h0 : m_opc + 32'd4);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    logic [31:0] frozen_addr;

    initial begin
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        step(); step();
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_addr", imem_addr, 32'h0);
        check("reset_fault", 32'(fault), 32'h0);

        // Streaming with decode always ready.
        rst = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stream_valid", 32'(out_valid), 32'h1);
            check("stream_pc", out_pc, 32'(4 * i));
            check("stream_instr", out_instr, 32'((i + 1) * 32'h11));
            check("stream_addr", imem_addr, 32'(4 * (i + 1)));
        end

        // Backpressure while out_pc=4.
        rst = 1'b1; step(); rst = 1'b0;
        step(); step();
        check("bp_pc_start", out_pc, 32'h4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_instr", out_instr, 32'h22);
            check("bp_pc", out_pc, 32'h4);
            check("bp_addr", imem_addr, 32'h8);
        end
        out_ready = 1'b1;
        step(); check("bp_resume8", out_pc, 32'h8); check("bp_instr8", out_instr, 32'h33);
        step(); check("bp_resume12", out_pc, 32'hC);

        // Redirect under backpressure flushes, target appears one edge later.
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        step(); redirect_valid = 1'b0;
        check("redir_flush", 32'(out_valid), 32'h0);
        check("redir_addr", imem_addr, 32'h100);
        step();
        check("redir_valid", 32'(out_valid), 32'h1);
        check("redir_pc", out_pc, 32'h100);
        check("redir_plus4", out_pc_plus4, 32'h104);

        // Wrap at the top of the address space; redirect wins over out_ready.
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); redirect_valid = 1'b0;
        check("wrap_flush", 32'(out_valid), 32'h0);
        step();
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_plus4", out_pc_plus4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        step();
        check("wrap_next", out_pc, 32'h0);
        check("wrap_next_instr", out_instr, 32'h11);

        // Reset mid-stream at out_pc=8 with decode stalled.
        step(); step();
        check("mid_pc8", out_pc, 32'h8);
        out_ready = 1'b0; rst = 1'b1;
        step();
        check("mid_valid", 32'(out_valid), 32'h0);
        check("mid_instr", out_instr, 32'h0);
        check("mid_pc", out_pc, 32'h0);
        check("mid_plus4", out_pc_plus4, 32'h0);
        check("mid_addr", imem_addr, 32'h0);

        // Misaligned redirect faults and freezes until reset.
        rst = 1'b0; out_ready = 1'b1;
        step(); step();
        frozen_addr = imem_addr;
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        step();
        check("fault_set", 32'(fault), 32'h1);
        check("fault_valid", 32'(out_valid), 32'h0);
        check("fault_addr", imem_addr, frozen_addr);
        redirect_pc = 32'h200;
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'(i);
            step();
            check("fault_hold", 32'(fault), 32'h1);
            check("fault_hold_valid", 32'(out_valid), 32'h0);
            check("fault_hold_addr", imem_addr, frozen_addr);
        end
        redirect_valid = 1'b0; rst = 1'b1;
        step();
        check("fault_clear", 32'(fault), 32'h0);
        check("fault_clear_addr", imem_addr, 32'h0);

        // Free run with a ready pattern; only the model checks here.
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            out_ready = 1'((i % 3) != 1);
            redirect_valid = (i == 10);
            redirect_pc = 32'h40;
            step();
        end
        redirect_valid = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
